adc_capture_ctrl: RTL and testbench

//  Sequencer for the smoothing ADC capture buffer: arms on host request, optionally waits for an

---
 rtl/adc_capture_ctrl_if.sv | 24 ++
 rtl/adc_capture_ctrl.sv | 161 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_ctrl_if.sv
// Buffer-side and stream-side signals of the ADC capture sequencer.
// master = the sequencer, slave = capture buffer plus packetiser.
interface adc_capture_ctrl_if;
  logic        iq_we;
  logic        cap_start;
  logic        cap_read;
  logic [15:0] cap_data_i;
  logic [15:0] cap_data_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_i;
  logic [15:0] out_q;
  logic        out_last;

  modport master (
    input  iq_we, cap_data_i, cap_data_q, out_ready,
    output cap_start, cap_read, out_valid, out_i, out_q, out_last
  );

  modport slave (
    output iq_we, cap_data_i, cap_data_q, out_ready,
    input  cap_start, cap_read, out_valid, out_i, out_q, out_last
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Arm / trigger / fill / drain sequencer for the smoothing ADC capture buffer.
// Defining ADC_CAPTURE_TIMEOUT_EN adds a FILL watchdog that drives err_timeout.
module adc_capture_ctrl #(
  parameter int DEPTH    = 1024,
  parameter int CNT_W    = 11,
  parameter int SETTLE   = 20,
  parameter int READ_LAT = 2,
  parameter int TIMEOUT  = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic abort,
  input  logic trig_mode,
  input  logic trig_ext,
  output logic busy,
  output logic done,
  output logic err_timeout,
  adc_capture_ctrl_if.master bus
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH >= (1 << CNT_W)) begin : g_bad_depth
    $error("adc_capture_ctrl: DEPTH must lie in 2..2**CNT_W-1");
  end
  if (SETTLE < 1 || READ_LAT < 1 || TIMEOUT < 1) begin : g_bad_timing
    $error("adc_capture_ctrl: SETTLE, READ_LAT and TIMEOUT must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE, ARMED, START, SETTLING, FILL, READ_REQ, READ_WAIT, PRESENT, DONE
  } state_t;

  state_t           state, state_n;
  logic             trig_ext_d;
  logic             trig_rise;
  logic             fill_last;
  logic             wd_expire;
  logic [SET_W-1:0] settle_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] read_cnt;

  assign trig_rise = trig_ext & ~trig_ext_d;
  assign fill_last = bus.iq_we && (sample_cnt == LAST_IDX);

`ifdef ADC_CAPTURE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // A completing strobe on the final watchdog cycle still wins over the timeout.
  assign wd_expire = (state == FILL) && !fill_last && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == FILL) ? wd_cnt + WD_W'(1) : '0;
      if (state == IDLE && arm && !abort)
        err_timeout <= 1'b0;
      else if (wd_expire && !abort)
        err_timeout <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (arm) state_n = ARMED;
      ARMED:     if (!trig_mode || trig_rise) state_n = START;
      START:     state_n = SETTLING;
      SETTLING:  if (settle_cnt == '0) state_n = FILL;
      FILL: begin
        if (fill_last)      state_n = READ_REQ;
        else if (wd_expire) state_n = IDLE;
      end
      READ_REQ:  state_n = READ_WAIT;
      READ_WAIT: if (lat_cnt == '0) state_n = PRESENT;
      PRESENT: begin
        if (bus.out_valid && bus.out_ready)
          state_n = bus.out_last ? DONE : READ_REQ;
      end
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    // Abort overrides everything, including an arm seen in IDLE.
    if (abort) state_n = IDLE;
  end

  // Strobes are decoded from the current state, so each appears one cycle after the state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      trig_ext_d    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      settle_cnt    <= '0;
      lat_cnt       <= '0;
      sample_cnt    <= '0;
      read_cnt      <= '0;
      bus.cap_start <= 1'b0;
      bus.cap_read  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_i     <= '0;
      bus.out_q     <= '0;
    end else begin
      state         <= state_n;
      trig_ext_d    <= trig_ext;
      busy          <= (state_n != IDLE);
      bus.cap_start <= (state == START) && !abort;
      bus.cap_read  <= (state == READ_REQ) && !abort;
      done          <= (state == DONE) && !abort;

      case (state)
        START:     settle_cnt <= SET_W'(SETTLE - 1);
        SETTLING: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
          else                  sample_cnt <= '0;
        end
        FILL: begin
          read_cnt <= '0;
          if (bus.iq_we) sample_cnt <= sample_cnt + CNT_W'(1);
        end
        READ_REQ:  lat_cnt <= LAT_W'(READ_LAT);
        READ_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            bus.out_i     <= bus.cap_data_i;
            bus.out_q     <= bus.cap_data_q;
            bus.out_valid <= 1'b1;
            bus.out_last  <= (read_cnt == LAST_IDX);
          end
        end
        PRESENT: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (!bus.out_last) read_cnt <= read_cnt + CNT_W'(1);
          end
        end
        DONE:      bus.out_last <= 1'b0;
        default: ;
      endcase

      if (abort && state != IDLE) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a READ_LAT capture-buffer model and stream monitor.
module tb_adc_capture_ctrl;
  localparam int DEPTH    = 8;
  localparam int READ_LAT = 2;
  localparam int TIMEOUT  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic trig_mode = 1'b0;
  logic trig_ext = 1'b0;
  logic busy, done, err_timeout;

  adc_capture_ctrl_if bif();

  adc_capture_ctrl #(
    .DEPTH(DEPTH), .CNT_W(11), .SETTLE(20), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .trig_ext(trig_ext), .busy(busy), .done(done), .err_timeout(err_timeout), .bus(bif)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Capture buffer: data for read k appears READ_LAT cycles after the cap_read cycle.
  int   buf_idx = 0;
  logic read_pend = 1'b0;
  logic read_fire = 1'b0;
  always @(posedge clk) begin
    read_fire = read_pend;
    read_pend = bif.cap_read;
    if (bif.cap_start) buf_idx = 0;
    #1;
    if (read_fire) begin
      bif.cap_data_i = 16'(16'h1000 + buf_idx);
      bif.cap_data_q = 16'(16'h8000 - buf_idx);
      buf_idx++;
    end
  end

  int          cycle = 0;
  int          n_start = 0, n_read = 0, n_done = 0, n_words = 0;
  int          n_stall = 0, stall_viol = 0;
  int          min_read_gap = 1000, last_read_cycle = -1;
  int          last_rise_cycle = 0, last_start_cycle = 0;
  logic        trig_prev = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0;
  logic [15:0] prev_i = '0, prev_q = '0;
  logic [15:0] word_i [0:63];
  logic [15:0] word_q [0:63];
  logic        word_last [0:63];

  // Monitor samples pre-edge values, i.e. what the DUT itself sees at this edge.
  always @(posedge clk) begin
    cycle++;
    if (!rst) begin
      if (bif.cap_start) begin n_start++; last_start_cycle = cycle; end
      if (bif.cap_read) begin
        n_read++;
        if (last_read_cycle >= 0 && cycle - last_read_cycle < min_read_gap)
          min_read_gap = cycle - last_read_cycle;
        last_read_cycle = cycle;
      end
      if (done) n_done++;
      if (trig_ext && !trig_prev) last_rise_cycle = cycle;
      if (prev_valid && !prev_ready && !prev_abort) begin
        n_stall++;
        if (!bif.out_valid || bif.out_i !== prev_i || bif.out_q !== prev_q) stall_viol++;
      end
      if (bif.out_valid && bif.out_ready && n_words < 64) begin
        word_i[n_words]    = bif.out_i;
        word_q[n_words]    = bif.out_q;
        word_last[n_words] = bif.out_last;
        n_words++;
      end
    end
    trig_prev  = trig_ext;
    prev_valid = bif.out_valid;
    prev_ready = bif.out_ready;
    prev_abort = abort;
    prev_i     = bif.out_i;
    prev_q     = bif.out_q;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic a_arm, input logic a_abort, input logic a_mode,
                                input logic a_trig, input logic a_we, input logic a_ready,
                                input int cycles);
    arm           = a_arm;
    abort         = a_abort;
    trig_mode     = a_mode;
    trig_ext      = a_trig;
    bif.iq_we     = a_we;
    bif.out_ready = a_ready;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = n_done;
    for (int i = 0; i < budget && n_done == base; i++) @(negedge clk);
    check_output(tag, 32'(n_done != base), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed cycle %0d required finish", cycle);
    $fatal(1, "[TB] simulation time limit");
  end

  int          b_start, b_read, b_done, b_words, b_stall;
  logic [15:0] rdy_pat = 16'b0110_1001_0011_0101;

  initial begin
    bif.iq_we = 1'b0;
    bif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err_timeout, 0);
    check_output("rst_start", bif.cap_start, 0);
    check_output("rst_read", bif.cap_read, 0);
    check_output("rst_valid", bif.out_valid, 0);
    check_output("rst_last", bif.out_last, 0);
    check_output("rst_out_i", bif.out_i, 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("idle_busy", busy, 0);

    $display("[TB] immediate capture");
    b_start = n_start; b_read = n_read; b_done = n_done; b_words = n_words;
    apply_stimulus(1, 0, 0, 0, 1, 1, 1);
    check_output("t1_busy", busy, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 5);
    apply_stimulus(1, 0, 0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    wait_done("t1_done", 400);
    check_output("t1_idle", busy, 0);
    check_output("t1_starts", n_start - b_start, 1);
    check_output("t1_reads", n_read - b_read, DEPTH);
    check_output("t1_words", n_words - b_words, DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      check_output("t1_word_i", word_i[b_words + k], 32'h1000 + k);
      check_output("t1_word_q", word_q[b_words + k], 32'h8000 - k);
      check_output("t1_word_last", word_last[b_words + k], (k == DEPTH - 1) ? 1 : 0);
    end
    apply_stimulus(0, 0, 0, 0, 1, 1, 5);
    check_output("t1_one_done", n_done - b_done, 1);

    $display("[TB] external trigger");
    b_start = n_start; b_words = n_words;
    apply_stimulus(1, 0, 1, 0, 1, 1, 1);
    apply_stimulus(0, 0, 1, 0, 1, 1, 100);
    check_output("t2_no_start", n_start - b_start, 0);
    check_output("t2_waiting", busy, 1);
    apply_stimulus(0, 0, 1, 1, 1, 1, 6);
    check_output("t2_one_start", n_start - b_start, 1);
    check_output("t2_latency", last_start_cycle - last_rise_cycle, 2);
    apply_stimulus(0, 0, 1, 0, 1, 1, 2);
    apply_stimulus(0, 0, 1, 1, 1, 1, 0);
    wait_done("t2_done", 400);
    check_output("t2_still_one_start", n_start - b_start, 1);
    check_output("t2_words", n_words - b_words, DEPTH);
    check_output("t2_last_word", word_i[b_words + DEPTH - 1], 32'h1000 + DEPTH - 1);

    $display("[TB] stalled stream");
    b_done = n_done; b_words = n_words; b_stall = n_stall;
    apply_stimulus(1, 0, 0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 800 && n_done == b_done; i++) begin
      bif.out_ready = rdy_pat[i % 16];
      @(negedge clk);
    end
    check_output("t3_done", n_done - b_done, 1);
    check_output("t3_words", n_words - b_words, DEPTH);
    for (int k = 0; k < DEPTH; k++)
      check_output("t3_order", word_i[b_words + k], 32'h1000 + k);
    check_output("t3_stalled", 32'(n_stall - b_stall > 0), 1);
    check_output("t3_stable", stall_viol, 0);

    $display("[TB] abort in FILL and PRESENT");
    b_read = n_read; b_done = n_done; b_words = n_words;
    apply_stimulus(1, 0, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 0, 1, 40);
    check_output("t4_in_fill", busy, 1);
    apply_stimulus(0, 1, 0, 0, 0, 1, 1);
    check_output("t4_fill_abort_busy", busy, 0);
    check_output("t4_fill_abort_valid", bif.out_valid, 0);
    apply_stimulus(0, 0, 0, 0, 1, 1, 10);
    check_output("t4_no_reads", n_read - b_read, 0);
    check_output("t4_still_idle", busy, 0);
    apply_stimulus(1, 0, 0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 200 && !bif.out_valid; i++) @(negedge clk);
    check_output("t4_present", bif.out_valid, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 3);
    check_output("t4_held_i", bif.out_i, 32'h1000);
    check_output("t4_held_q", bif.out_q, 32'h8000);
    apply_stimulus(0, 1, 0, 0, 1, 0, 1);
    check_output("t4_present_abort_valid", bif.out_valid, 0);
    check_output("t4_present_abort_last", bif.out_last, 0);
    check_output("t4_present_abort_busy", busy, 0);
    apply_stimulus(0, 0, 0, 0, 1, 1, 10);
    check_output("t4_no_done", n_done - b_done, 0);
    check_output("t4_no_words", n_words - b_words, 0);
    apply_stimulus(1, 0, 0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    wait_done("t4_recover_done", 400);
    check_output("t4_recover_words", n_words - b_words, DEPTH);
    check_output("t4_recover_first", word_i[b_words], 32'h1000);
    check_output("t4_recover_last", word_last[b_words + DEPTH - 1], 1);

    $display("[TB] arm with abort");
    b_start = n_start;
    apply_stimulus(1, 1, 0, 0, 1, 1, 1);
    check_output("t5_busy", busy, 0);
    apply_stimulus(0, 0, 0, 0, 1, 1, 30);
    check_output("t5_busy_later", busy, 0);
    check_output("t5_no_start", n_start - b_start, 0);

    $display("[TB] starved FILL");
    apply_stimulus(1, 0, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 0, 1, 100);
`ifdef ADC_CAPTURE_TIMEOUT_EN
    check_output("t6_timeout_err", err_timeout, 1);
    check_output("t6_timeout_idle", busy, 0);
    apply_stimulus(1, 0, 1, 0, 0, 1, 1);
    check_output("t6_err_cleared", err_timeout, 0);
    check_output("t6_rearmed", busy, 1);
`else
    check_output("t6_no_err", err_timeout, 0);
    check_output("t6_still_busy", busy, 1);
`endif
    apply_stimulus(0, 1, 0, 0, 0, 1, 1);
    check_output("t6_abort_idle", busy, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 2);

    check_output("read_spacing", 32'(min_read_gap >= READ_LAT + 2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
